// File: rtl/match_controller.sv
// match_controller: quidditch round/match sequencer driving ball run/respawn, scores and winner
module match_controller #(
  parameter int WIN_SCORE   = 7,
  parameter int SCORE_WIDTH = 4,
  parameter int SERVE_DELAY = 50000000,
  parameter int GOAL_HOLD   = 25000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_n,
  input  logic                   score_to_team1,
  input  logic                   score_to_team2,
  output logic                   ball_enable,
  output logic                   ball_respawn,
  output logic                   serve_to_team1,
  output logic [SCORE_WIDTH-1:0] team1_score,
  output logic [SCORE_WIDTH-1:0] team2_score,
  output logic                   goal_flash,
  output logic [1:0]             winner
);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, GOAL, OVER} state_t;
  localparam logic [SCORE_WIDTH-1:0] win_s = SCORE_WIDTH'(WIN_SCORE);
  localparam logic [31:0] serve_end = 32'(SERVE_DELAY - 1);
  localparam logic [31:0] goal_end = 32'(GOAL_HOLD - 1);
  state_t st, st_n;
  logic [31:0] tmr, tmr_n;
  logic s1, s2, s3, f1_r, f1_d, f2_r, f2_d;
  logic press, e1, e2, resp_n, srv_n;
  logic [SCORE_WIDTH-1:0] t1_n, t2_n;
  logic [1:0] win_n;
  assign press = s3 & ~s2;
  assign e1 = f1_r & ~f1_d;
  assign e2 = f2_r & ~f2_d;
  always_comb begin
    st_n = st;
    tmr_n = '0;
    resp_n = 1'b0;
    srv_n = serve_to_team1;
    t1_n = team1_score;
    t2_n = team2_score;
    win_n = winner;
    case (st)
      IDLE: begin
        st_n = press ? SERVE : IDLE;
        resp_n = press;
      end
      SERVE: begin
        st_n = (tmr == serve_end) ? PLAY : SERVE;
        tmr_n = (tmr == serve_end) ? '0 : tmr + 32'd1;
      end
      PLAY: begin
        st_n = (e1 | e2) ? GOAL : PLAY;
        t1_n = (e1 & ~e2 & team1_score != win_s) ? team1_score + 1'b1 : team1_score;
        t2_n = (e2 & ~e1 & team2_score != win_s) ? team2_score + 1'b1 : team2_score;
        srv_n = (e1 ^ e2) ? e2 : serve_to_team1;
      end
      GOAL: begin
        tmr_n = (tmr == goal_end) ? '0 : tmr + 32'd1;
        if (tmr == goal_end) begin
          st_n = (team1_score == win_s || team2_score == win_s) ? OVER : SERVE;
          resp_n = !(team1_score == win_s || team2_score == win_s);
          win_n = {team2_score == win_s, team1_score == win_s};
        end
      end
      OVER: begin
        st_n = press ? SERVE : OVER;
        resp_n = press;
        t1_n = press ? '0 : team1_score;
        t2_n = press ? '0 : team2_score;
        win_n = press ? 2'b00 : winner;
        srv_n = press ? 1'b0 : serve_to_team1;
      end
      default: st_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      tmr <= '0;
      {s1, s2, s3} <= 3'b111;
      {f1_r, f1_d, f2_r, f2_d} <= 4'b0000;
      ball_enable <= 1'b0;
      ball_respawn <= 1'b0;
      serve_to_team1 <= 1'b0;
      team1_score <= '0;
      team2_score <= '0;
      goal_flash <= 1'b0;
      winner <= 2'b00;
    end else begin
      st <= st_n;
      tmr <= tmr_n;
      {s1, s2, s3} <= {start_n, s1, s2};
      {f1_r, f1_d, f2_r, f2_d} <= {score_to_team1, f1_r, score_to_team2, f2_r};
      ball_enable <= st_n == PLAY;
      ball_respawn <= resp_n;
      serve_to_team1 <= srv_n;
      team1_score <= t1_n;
      team2_score <= t2_n;
      goal_flash <= st_n == GOAL;
      winner <= win_n;
    end
  end
endmodule
